// File: rtl/ms_stopwatch.sv
// ms_stopwatch: measures elapsed ms between start and stop pulses by counting clk1kHz rising edges.
// Define MS_STOPWATCH_SYNC_EN to pass clk1kHz through a 2-flop synchronizer first.
module ms_stopwatch #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             clk1kHz,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] elapsedMs,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]       state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] nextCount;
  logic             satFlag;
  logic             tickPrev;
  logic             s;
  logic             tick;
  logic             atMax;
`ifdef MS_STOPWATCH_SYNC_EN
  logic [1:0] syncFf;
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) syncFf <= '0;
    else syncFf <= {syncFf[0], clk1kHz};
  assign s = syncFf[1];
`else
  assign s = clk1kHz;
`endif
  assign tick      = s & ~tickPrev;
  assign atMax     = &count;
  assign nextCount = count + {{(WIDTH-1){1'b0}}, tick & ~atMax};
  assign busy      = state == RUN;
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      count     <= '0;
      satFlag   <= 1'b0;
      tickPrev  <= 1'b0;
      elapsedMs <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      tickPrev <= s;
      valid    <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state   <= RUN;
          count   <= '0;
          satFlag <= 1'b0;
        end
      end else if (stop) begin
        // a tick landing on the stop cycle still counts toward the capture
        elapsedMs <= nextCount;
        overflow  <= satFlag | (tick & atMax);
        valid     <= 1'b1;
        count     <= '0;
        satFlag   <= 1'b0;
        state     <= start ? RUN : IDLE;
      end else if (start) begin
        count   <= '0;
        satFlag <= 1'b0;
      end else if (tick) begin
        if (atMax) satFlag <= 1'b1;
        else count <= count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ms_stopwatch.sv
// tb_ms_stopwatch: scoreboard bench; expected captures queued at each stop, popped on valid.
module tb_ms_stopwatch;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         nReset = 1'b0;
  logic         clk1kHz = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] elapsedMs;
  logic         valid;
  logic         busy;
  logic         overflow;
  typedef struct {
    logic [W-1:0] ms;
    logic         ov;
    int           cyc;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int nChecks = 0;
  int nErrors = 0;
  always #5 clk = ~clk;
  ms_stopwatch #(.WIDTH(W)) dut (
    .clk(clk),
    .nReset(nReset),
    .clk1kHz(clk1kHz),
    .start(start),
    .stop(stop),
    .elapsedMs(elapsedMs),
    .valid(valid),
    .busy(busy),
    .overflow(overflow)
  );
  task automatic check(input string tag, input int got, input int want);
    nChecks++;
    if (got != want) begin
      nErrors++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask
  task automatic monitor();
    exp_t e;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("missedValid", cyc, e.cyc);
    end
    if (valid) begin
      if (q.size() == 0) check("spuriousValid", 1, 0);
      else begin
        e = q.pop_front();
        check("elapsedMs", elapsedMs, e.ms);
        check("overflow", overflow, e.ov);
        check("validCycle", cyc, e.cyc);
      end
    end
  endtask
  task automatic step(input logic st, input logic sp, input logic k);
    start = st;
    stop = sp;
    clk1kHz = k;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask
  task automatic go();
    idle(4);
    step(1'b1, 1'b0, 1'b0);
  endtask
  task automatic measStop(input logic st, input logic k, input logic [W-1:0] ms, input logic ov);
    q.push_back('{ms, ov, cyc + 1});
    step(st, 1'b1, k);
  endtask
  initial begin
    idle(3);
    check("rstElapsed", elapsedMs, 0);
    check("rstValid", valid, 0);
    check("rstBusy", busy, 0);
    check("rstOverflow", overflow, 0);
    nReset = 1'b1;
    go();
    check("busyRise", busy, 1);
    ticks(10);
    idle(3);
    measStop(1'b0, 1'b0, 4'd10, 1'b0);
    check("busyFall", busy, 0);
    go();
    ticks(5);
    idle(3);
    step(1'b1, 1'b0, 1'b0);
    ticks(3);
    idle(3);
    measStop(1'b0, 1'b0, 4'd3, 1'b0);
    go();
    ticks(7);
    idle(3);
    measStop(1'b1, 1'b0, 4'd7, 1'b0);
    check("lapBusy", busy, 1);
    ticks(4);
    idle(3);
    measStop(1'b0, 1'b0, 4'd4, 1'b0);
    go();
    ticks(20);
    idle(3);
    measStop(1'b0, 1'b0, 4'd15, 1'b1);
    go();
    ticks(2);
    idle(3);
    measStop(1'b0, 1'b0, 4'd2, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    ticks(3);
    idle(3);
    check("idleHold", elapsedMs, 2);
    check("idleBusy", busy, 0);
    go();
    ticks(3);
`ifdef MS_STOPWATCH_SYNC_EN
    measStop(1'b0, 1'b1, 4'd3, 1'b0);
`else
    measStop(1'b0, 1'b1, 4'd4, 1'b0);
`endif
    idle(4);
    go();
    ticks(6);
    nReset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("midRstElapsed", elapsedMs, 0);
    check("midRstBusy", busy, 0);
    check("midRstOverflow", overflow, 0);
    nReset = 1'b1;
    idle(4);
    check("postRstElapsed", elapsedMs, 0);
    go();
    ticks(10);
    idle(3);
    measStop(1'b0, 1'b0, 4'd10, 1'b0);
    idle(2);
    check("pending", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule

// File: doc/ms_stopwatch.md
Name: ms_stopwatch

Overview:
- Measures elapsed milliseconds between a start event and a stop event by counting rising edges of the shared 1 kHz tick (clk1kHz), sampled in the system clock domain.
- It is the measuring counterpart of the delay timer: the timer turns a millisecond count into an event, and this block turns a pair of events into a millisecond count.
- Used for button-press duration, debounce calibration and latency measurement on the board.
- Reports the result with a one-cycle valid strobe and a saturation flag.

Parameters:
- WIDTH, 10, width of the millisecond counter and result; the counter saturates at 2^WIDTH-1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- clk1kHz  in  1  1 kHz tick level signal, sampled on clk.
- start  in  1  single-cycle pulse that begins or restarts a measurement.
- stop  in  1  single-cycle pulse that ends a measurement and captures the result.
- elapsedMs  out  WIDTH  last captured millisecond count.
- valid  out  1  one-cycle strobe; elapsedMs and overflow are new.
- busy  out  1  high while a measurement is running.
- overflow  out  1  captured with elapsedMs; 1 if the count saturated during that measurement.

Behaviour:
- Reset (nReset low, async):
  - state=IDLE, count=0, satFlag=0, tickPrev=0.
  - elapsedMs=0, valid=0, busy=0, overflow=0.
- Tick detect:
  - tick = s & ~tickPrev, where s is the sampled clk1kHz; tickPrev <= s every cycle, in all states.
  - The first cycle after reset never produces a tick if clk1kHz is already high? No: with tickPrev=0 and s=1, it does produce one, which is harmless because ticks in IDLE are ignored.
- States: IDLE, RUN. busy = (state==RUN), registered.
- IDLE:
  - start -> RUN, count=0, satFlag=0.
  - stop alone is ignored: no valid, outputs hold.
  - tick is ignored.
- RUN, per cycle, in this priority:
  - stop: next = count+tick (saturating).
    - elapsedMs <= next; overflow <= satFlag | saturation caused by this tick; valid <= 1 on the next cycle (registered).
    - If start is also high in the same cycle (lap): stay in RUN with count=0, satFlag=0.
    - Otherwise go to IDLE.
  - start without stop: retrigger. count=0, satFlag=0, stay in RUN; no valid and no capture.
  - tick: if count==2^WIDTH-1, hold count and set satFlag=1; else count <= count+1.
- Ticks detected in the same cycle as the IDLE->RUN start are not counted; counting starts from the next cycle.
- Latency:
  - valid is asserted exactly 1 clk after the stop cycle, for 1 clk.
  - elapsedMs and overflow change only on the same edge that raises valid, and hold until the next capture.
- Back-to-back stops: every RUN-state stop produces its own valid.
- Width rule: all arithmetic is WIDTH bits and saturating; the counter never wraps.
- Reset mid-measurement: immediate return to the reset values; no valid is produced.

Optional Feature:
- Macro: MS_STOPWATCH_SYNC_EN.
- Defined: clk1kHz passes through a 2-flop synchronizer before tick detection (s = second flop). Both flops reset to 0. Tick detection is delayed 2 clk relative to the input edge; start/stop handling is unchanged.
- Undefined: s = clk1kHz directly, for use when clk1kHz is generated in the clk domain, e.g. by a divider.

Test Plan:
- Counting: reset; clk1kHz toggles every clk (tick every 2 clk); start; run 10 ticks; stop -> valid for 1 clk, 1 clk after stop; elapsedMs=10, overflow=0; busy falls.
- Retrigger: start; 5 ticks; start again; 3 ticks; stop -> elapsedMs=3; exactly one valid pulse.
- Lap: start+stop in the same cycle after 7 ticks -> elapsedMs=7, valid=1, busy stays 1; 4 more ticks, then stop -> elapsedMs=4.
- Saturation: WIDTH=4; start; 20 ticks; stop -> elapsedMs=15, overflow=1. Next measurement of 2 ticks -> elapsedMs=2, overflow=0.
- Idle events: stop in IDLE and ticks in IDLE -> no valid; elapsedMs holds its previous value.
- Reset mid-run: start; 6 ticks; nReset low for 1 clk -> elapsedMs=0, busy=0, valid never asserted. With MS_STOPWATCH_SYNC_EN, repeat the counting test -> elapsedMs=10.
